// File: rtl/vid_pattern_gen.sv
// Video raster timing and test-pattern source for the HDMI TX parallel input.
// Whole frames only: enable is sampled when idle or on the last pixel of a frame.
module vid_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int BAR_W    = 160
) (
  input  logic        vid_clk,
  input  logic        vid_reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [35:0] solid_rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [35:0] d,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  logic        running_q, running_d;
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] bar_sub_q, bar_sub_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  pat_q, pat_d;
  logic [35:0] rgb_q, rgb_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [35:0] d_q, d_d;
  logic        last_px_s, frame_s, active_s;
  logic [35:0] pix_s;

  // State register: run flag, raster counters, bar counter, latched pattern and pins.
  always_ff @(posedge vid_clk or negedge vid_reset_n) begin
    if (!vid_reset_n) begin
      running_q <= 1'b0;
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 12'd0;
      bar_sub_q <= 12'd0;
      bar_idx_q <= 3'd0;
      pat_q     <= 2'd0;
      rgb_q     <= 36'd0;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      d_q       <= 36'd0;
      fs_q      <= 1'b0;
    end else begin
      running_q <= running_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_sub_q <= bar_sub_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      d_q       <= d_d;
      fs_q      <= fs_d;
    end
  end

  // Next state: run flag, raster counters and the divider-free bar counter.
  always_comb begin
    last_px_s = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    frame_s   = running_q && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    running_d = running_q;
    if (!running_q || last_px_s) begin
      running_d = enable;
    end else begin
      running_d = running_q;
    end
    h_cnt_d   = 12'd0;
    v_cnt_d   = 12'd0;
    bar_sub_d = 12'd0;
    bar_idx_d = 3'd0;
    if (running_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 12'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (bar_sub_q == BAR_LAST) begin
          bar_sub_d = 12'd0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_sub_d = bar_sub_q + 12'd1;
          bar_idx_d = bar_idx_q;
        end
      end
    end else begin
      h_cnt_d = 12'd0;
    end
    // The frame's first pixel already uses the freshly latched selection.
    pat_d = frame_s ? pattern_sel : pat_q;
    rgb_d = frame_s ? solid_rgb : rgb_q;
  end

  // Output decode: timing windows and pixel colour, registered next edge.
  always_comb begin
    active_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    case (pat_d)
      2'd0:    pix_s = {{12{~bar_idx_q[2]}}, {12{~bar_idx_q[1]}}, {12{~bar_idx_q[0]}}};
      2'd1:    pix_s = {3{h_cnt_q[7:0], 4'h0}};
      2'd2:    pix_s = {36{h_cnt_q[5] ^ v_cnt_q[5]}};
      2'd3:    pix_s = rgb_d;
      default: pix_s = 36'd0;
    endcase
    if (running_q) begin
      de_d = active_s;
      hs_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
      d_d  = active_s ? pix_s : 36'd0;
      fs_d = frame_s;
    end else begin
      de_d = 1'b0;
      hs_d = ~HS_POL;
      vs_d = ~VS_POL;
      d_d  = 36'd0;
      fs_d = 1'b0;
    end
  end

  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign d           = d_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench: small-raster instance for timing/patterns/enable/reset,
// two 720p instances for line length, ramp value and checker pattern.
module tb_vid_pattern_gen;

  logic        vid_clk = 1'b0;
  logic        vid_reset_n;
  logic        en_s, en_b;
  logic [1:0]  sel_s;
  logic [35:0] rgb_s;
  logic        de_s, hs_s, vs_s, fs_s;
  logic [35:0] d_s;
  logic        de_r, hs_r, vs_r, fs_r;
  logic [35:0] d_r;
  logic        de_c, hs_c, vs_c, fs_c;
  logic [35:0] d_c;
  int checks = 0;
  int errors = 0;
  logic [1:0] frame_pat [3];

  always #5 vid_clk = ~vid_clk;

  vid_pattern_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .BAR_W(1)) u_s (
    .vid_clk(vid_clk), .vid_reset_n(vid_reset_n), .enable(en_s), .pattern_sel(sel_s),
    .solid_rgb(rgb_s), .de(de_s), .hsync(hs_s), .vsync(vs_s), .d(d_s), .frame_start(fs_s));

  vid_pattern_gen u_r (
    .vid_clk(vid_clk), .vid_reset_n(vid_reset_n), .enable(en_b), .pattern_sel(2'd1),
    .solid_rgb(36'd0), .de(de_r), .hsync(hs_r), .vsync(vs_r), .d(d_r), .frame_start(fs_r));

  vid_pattern_gen u_c (
    .vid_clk(vid_clk), .vid_reset_n(vid_reset_n), .enable(en_b), .pattern_sel(2'd2),
    .solid_rgb(36'd0), .de(de_c), .hsync(hs_c), .vsync(vs_c), .d(d_c), .frame_start(fs_c));

  // Expected {frame_start,de,hsync,vsync,d} for output pixel p of a 16x8 small raster.
  function automatic logic [39:0] model(int p, logic [1:0] pat, logic [35:0] rgb);
    int h, v;
    logic [11:0] hv, vv;
    logic [2:0]  k;
    logic        fs, act, hs, vs;
    logic [35:0] dd;
    h   = p % 16;
    v   = (p / 16) % 8;
    hv  = 12'(h);
    vv  = 12'(v);
    k   = 3'(h);
    fs  = (p % 128) == 0;
    act = (h < 8) && (v < 4);
    hs  = (h >= 10) && (h < 12);
    vs  = (v == 5);
    case (pat)
      2'd0:    dd = {{12{~k[2]}}, {12{~k[1]}}, {12{~k[0]}}};
      2'd1:    dd = {3{hv[7:0], 4'h0}};
      2'd2:    dd = {36{hv[5] ^ vv[5]}};
      default: dd = rgb;
    endcase
    if (!act) dd = 36'd0;
    return {fs, act, hs, vs, dd};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vid_clk);
    #1;
  endtask

  initial begin
    vid_reset_n = 1'b0;
    en_s = 1'b0; en_b = 1'b0; sel_s = 2'd0; rgb_s = 36'd0;
    frame_pat[0] = 2'd0; frame_pat[1] = 2'd3; frame_pat[2] = 2'd1;
    #12;
    chk("reset_state", {fs_s, de_s, hs_s, vs_s, d_s}, 40'd0);
    @(negedge vid_clk);
    vid_reset_n = 1'b1;

    // Idle with enable low: nothing ever leaves the block.
    for (int i = 0; i < 100; i++) begin
      step();
      chk($sformatf("idle_%0d", i), {fs_s, de_s, hs_s, vs_s, d_s}, 40'd0);
    end

    // Three frames: bars, solid (selected mid-frame), ramp; enable dropped on line 1 of the last.
    en_s = 1'b1;
    step();
    for (int p = 0; p < 384; p++) begin
      step();
      chk($sformatf("frame%0d_px%0d", p / 128, p % 128), {fs_s, de_s, hs_s, vs_s, d_s},
          model(p % 128, frame_pat[p / 128], 36'h123456789));
      if (p == 60) begin
        sel_s = 2'd3;
        rgb_s = 36'h123456789;
      end
      if (p == 128 + 50) sel_s = 2'd1;
      if (p == 256 + 20) en_s = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("post_frame_idle_%0d", i), {fs_s, de_s, hs_s, vs_s, d_s}, 40'd0);
    end

    // Resume: one load cycle, then pixel (0,0) with frame_start.
    en_s = 1'b1;
    step();
    chk("resume_load", {fs_s, de_s, hs_s, vs_s, d_s}, 40'd0);
    for (int p = 0; p <= 36; p++) begin
      step();
      chk($sformatf("resume_px%0d", p), {fs_s, de_s, hs_s, vs_s, d_s}, model(p, 2'd1, 36'd0));
    end

    // Asynchronous reset mid-line: outputs clear without a clock edge.
    vid_reset_n = 1'b0;
    #1;
    chk("async_reset", {fs_s, de_s, hs_s, vs_s, d_s}, 40'd0);
    repeat (3) @(posedge vid_clk);
    #1;
    chk("reset_held", {fs_s, de_s, hs_s, vs_s, d_s}, 40'd0);
    @(negedge vid_clk);
    vid_reset_n = 1'b1;
    step();
    chk("restart_load", {fs_s, de_s, hs_s, vs_s, d_s}, 40'd0);
    for (int p = 0; p < 24; p++) begin
      step();
      chk($sformatf("restart_px%0d", p), {fs_s, de_s, hs_s, vs_s, d_s}, model(p, 2'd1, 36'd0));
    end

    // 720p instances: ramp and checker on the first lines.
    en_b = 1'b1;
    step();
    for (int n = 0; n <= 1700; n++) begin
      step();
      if (n == 0)    chk("hd_fs0",     {fs_r, de_r, hs_r, vs_r, d_r}, {4'b1100, 36'd0});
      if (n == 300)  chk("hd_ramp300", {fs_r, de_r, hs_r, vs_r, d_r}, {4'b0100, 36'h2C02C02C0});
      if (n == 1279) chk("hd_de_last", {fs_r, de_r, hs_r, vs_r, d_r}, {4'b0100, 36'hFF0FF0FF0});
      if (n == 1280) chk("hd_de_fall", {fs_r, de_r, hs_r, vs_r, d_r}, 40'd0);
      if (n == 1389) chk("hd_hs_pre",  {1'b0, hs_r}, 2'b00);
      if (n == 1390) chk("hd_hs_rise", {1'b0, hs_r}, 2'b01);
      if (n == 1429) chk("hd_hs_last", {1'b0, hs_r}, 2'b01);
      if (n == 1430) chk("hd_hs_fall", {1'b0, hs_r}, 2'b00);
      if (n == 1649) chk("hd_blank",   {fs_r, de_r, vs_r}, 3'b000);
      if (n == 1650) chk("hd_line1",   {fs_r, de_r, hs_r, vs_r, d_r}, {4'b0100, 36'd0});
      if (n == 31)   chk("chk_px31",   {de_c, d_c}, {1'b1, 36'd0});
      if (n == 32)   chk("chk_px32",   {de_c, d_c}, {1'b1, 36'hFFFFFFFFF});
      if (n == 64)   chk("chk_px64",   {de_c, d_c}, {1'b1, 36'd0});
      if (n == 1682) chk("chk_l1_px32", {fs_c, de_c, d_c}, {2'b01, 36'hFFFFFFFFF});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
